// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Module  : eth_pkg
// Brief   : Shared Ethernet FCS constants, error bit indices and state type.
// Revision: 1.0 - initial release
// ============================================================================
package eth_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    localparam int ERR_CRC   = 0;
    localparam int ERR_RUNT  = 1;
    localparam int ERR_GIANT = 2;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        IDLE  = 2'd1,
        FRAME = 2'd2
    } fcs_state_t;

endpackage
`default_nettype wire

// File: rtl/eth_crc32_d8.sv
`default_nettype none
// ============================================================================
// Module  : eth_crc32_d8
// Brief   : Combinational reflected CRC-32 update over one byte, LSB first.
// Revision: 1.0 - initial release
// ============================================================================
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  d,
    output logic [31:0] crc_out
);

    logic [31:0] w_c;

    always_comb begin
        w_c = crc_in;
        for (int i = 0; i < 8; i++) begin
            w_c = (w_c[0] ^ d[i]) ? ((w_c >> 1) ^ CRC32_POLY) : (w_c >> 1);
        end
    end

    assign crc_out = w_c;

endmodule
`default_nettype wire

// File: rtl/eth_rx_fcs_check.sv
`default_nettype none
// ============================================================================
// Module  : eth_rx_fcs_check
// Brief   : Checks Ethernet FCS and length, strips FCS, forwards payload bytes.
//           Optional frame statistics outputs when ETH_RX_STATS_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module eth_rx_fcs_check
    import eth_pkg::*;
#(
    parameter int MIN_LEN   = 64,
    parameter int MAX_LEN   = 1518,
    parameter int SYNC_IDLE = 64
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_eop,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    output logic [2:0]  out_err,
    output logic        out_drop
`ifdef ETH_RX_STATS_EN
    ,
    output logic [15:0] stat_ok,
    output logic [15:0] stat_bad
`endif
);

    localparam int              IDLE_W      = $clog2(SYNC_IDLE);
    localparam logic [IDLE_W-1:0] C_IDLE_LAST = IDLE_W'(SYNC_IDLE - 1);
    localparam logic [10:0]     C_MIN_LEN   = 11'(MIN_LEN);
    localparam logic [10:0]     C_MAX_LEN   = 11'(MAX_LEN);
    localparam logic [10:0]     C_LEN_SAT   = 11'h7FF;

    fcs_state_t        r_state, w_state;
    logic [4:0][7:0]   r_dly,   w_dly;
    logic [2:0]        r_cnt,   w_cnt;
    logic [31:0]       r_crc,   w_crc;
    logic [10:0]       r_len,   w_len;
    logic [IDLE_W-1:0] r_idle,  w_idle;

    logic [31:0]       w_crc_upd;
    logic [7:0]        w_out_data;
    logic              w_out_valid;
    logic              w_out_last;
    logic [2:0]        w_out_err;
    logic              w_out_drop;

    // r_crc sits at CRC32_INIT whenever the FSM is idle, so one update path serves all.
    eth_crc32_d8 u_crc (
        .crc_in  (r_crc),
        .d       (in_data),
        .crc_out (w_crc_upd)
    );

    always_comb begin
        w_state     = r_state;
        w_dly       = r_dly;
        w_cnt       = r_cnt;
        w_crc       = r_crc;
        w_len       = r_len;
        w_idle      = r_idle;
        w_out_data  = 8'h00;
        w_out_valid = 1'b0;
        w_out_last  = 1'b0;
        w_out_err   = 3'b000;
        w_out_drop  = 1'b0;

        case (r_state)
            SYNC: begin
                if (in_eop || (!in_valid && r_idle == C_IDLE_LAST)) begin
                    w_state = IDLE;
                    w_idle  = '0;
                end else if (in_valid) begin
                    w_idle = '0;
                end else begin
                    w_idle = r_idle + 1'b1;
                end
            end

            IDLE: begin
                if (in_valid && !in_eop) begin
                    w_state = FRAME;
                    w_dly   = {32'h0, in_data};
                    w_cnt   = 3'd1;
                    w_len   = 11'd1;
                    w_crc   = w_crc_upd;
                end
            end

            FRAME: begin
                if (in_eop) begin
                    if (r_cnt == 3'd5) begin
                        w_out_data           = r_dly[4];
                        w_out_valid          = 1'b1;
                        w_out_last           = 1'b1;
                        w_out_err[ERR_CRC]   = (r_crc != CRC32_RESIDUE);
                        w_out_err[ERR_RUNT]  = (r_len < C_MIN_LEN);
                        w_out_err[ERR_GIANT] = (r_len > C_MAX_LEN);
                    end else begin
                        w_out_drop = 1'b1;
                    end
                    w_dly   = '0;
                    w_cnt   = 3'd0;
                    w_crc   = CRC32_INIT;
                    w_len   = 11'd0;
                    w_state = IDLE;
                end else if (in_valid) begin
                    w_crc = w_crc_upd;
                    w_dly = {r_dly[3:0], in_data};
                    w_len = (r_len == C_LEN_SAT) ? r_len : r_len + 11'd1;
                    if (r_cnt == 3'd5) begin
                        w_out_data  = r_dly[4];
                        w_out_valid = 1'b1;
                    end else begin
                        w_cnt = r_cnt + 3'd1;
                    end
                end
            end

            default: w_state = SYNC;
        endcase
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_state   <= SYNC;
            r_dly     <= '0;
            r_cnt     <= 3'd0;
            r_crc     <= CRC32_INIT;
            r_len     <= 11'd0;
            r_idle    <= '0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_err   <= 3'b000;
            out_drop  <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_dly     <= w_dly;
            r_cnt     <= w_cnt;
            r_crc     <= w_crc;
            r_len     <= w_len;
            r_idle    <= w_idle;
            out_data  <= w_out_data;
            out_valid <= w_out_valid;
            out_last  <= w_out_last;
            out_err   <= w_out_err;
            out_drop  <= w_out_drop;
        end
    end

`ifdef ETH_RX_STATS_EN
    logic w_cnt_ok;
    logic w_cnt_bad;

    assign w_cnt_ok  = w_out_last && (w_out_err == 3'b000);
    assign w_cnt_bad = (w_out_last && (w_out_err != 3'b000)) || w_out_drop;

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            stat_ok  <= 16'h0000;
            stat_bad <= 16'h0000;
        end else begin
            if (w_cnt_ok && stat_ok != 16'hFFFF) begin
                stat_ok <= stat_ok + 16'h0001;
            end
            if (w_cnt_bad && stat_bad != 16'hFFFF) begin
                stat_bad <= stat_bad + 16'h0001;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_fcs_check.sv
`default_nettype none
// ============================================================================
// Module  : tb_eth_rx_fcs_check
// Brief   : Scoreboard bench for eth_rx_fcs_check with a frame-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_eth_rx_fcs_check;

    logic        clk50 = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_eop;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic [2:0]  out_err;
    logic        out_drop;
`ifdef ETH_RX_STATS_EN
    logic [15:0] stat_ok;
    logic [15:0] stat_bad;
`endif

    always #10 clk50 = ~clk50;

    eth_rx_fcs_check dut (
        .clk50     (clk50),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_eop    (in_eop),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_err   (out_err),
        .out_drop  (out_drop)
`ifdef ETH_RX_STATS_EN
        ,
        .stat_ok   (stat_ok),
        .stat_bad  (stat_bad)
`endif
    );

    typedef struct {
        bit         drop;
        logic [7:0] data;
        bit         last;
        logic [2:0] err;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] frm[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         exp_ok  = 0;
    int         exp_bad = 0;

    // Plain bitwise CRC-32 over the first cnt bytes of the frame buffer.
    function automatic logic [31:0] crc_of(input int cnt);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < cnt; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ frm[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return c;
    endfunction

    task automatic build(input int n, input bit bad_fcs);
        logic [31:0] f;
        frm.delete();
        if (n < 4) begin
            for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
        end else begin
            for (int i = 0; i < n - 4; i++) frm.push_back(8'($urandom));
            f = ~crc_of(n - 4);
            frm.push_back(f[7:0]);
            frm.push_back(f[15:8]);
            frm.push_back(f[23:16]);
            frm.push_back(f[31:24]);
            if (bad_fcs) frm[n-4] = frm[n-4] ^ 8'h01;
        end
    endtask

    // Expected response: payload bytes, last marker and error flags, or a drop.
    // A non-negative rst_at means reset hits at that byte: only beats already due come out.
    task automatic expect_frame(input int rst_at);
        int          n;
        exp_t        e;
        logic [2:0]  err;
        logic [31:0] rx_fcs;
        n = frm.size();
        if (rst_at >= 0) begin
            for (int i = 0; i < rst_at - 5; i++) begin
                e = '{drop: 1'b0, data: frm[i], last: 1'b0, err: 3'b000};
                sb.push_back(e);
            end
        end else if (n < 5) begin
            e = '{drop: 1'b1, data: 8'h00, last: 1'b0, err: 3'b000};
            sb.push_back(e);
            exp_bad++;
        end else begin
            rx_fcs = {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
            err[0] = (rx_fcs != ~crc_of(n - 4));
            err[1] = (n < 64);
            err[2] = (n > 1518);
            for (int i = 0; i <= n - 5; i++) begin
                e = '{drop: 1'b0, data: frm[i], last: (i == n - 5), err: (i == n - 5) ? err : 3'b000};
                sb.push_back(e);
            end
            if (err == 3'b000) exp_ok++;
            else               exp_bad++;
        end
    endtask

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    task automatic check_quiet(input string name);
        n_tests++;
        if (out_valid || out_last || out_drop || out_err != 3'b000 || out_data != 8'h00) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b last=%0b drop=%0b err=%03b data=%02h, need all zero",
                     name, out_valid, out_last, out_drop, out_err, out_data);
        end
    endtask

    task automatic send(input int gap, input int rst_at, input int rst_rel);
        for (int i = 0; i < frm.size(); i++) begin
            if (i == rst_at) begin
                reset = 1'b1;
                #1;
                check_quiet("reset_mid_frame");
            end
            if (i == rst_rel) reset = 1'b0;
            in_data  = frm[i];
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            repeat (gap) tick();
        end
        in_eop = 1'b1;
        tick();
        in_eop = 1'b0;
        repeat (2) tick();
    endtask

    task automatic run_frame(input int n, input bit bad_fcs, input int gap);
        build(n, bad_fcs);
        expect_frame(-1);
        send(gap, -1, -1);
    endtask

    // Monitor: pops one expectation per output event.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk50);
            if (out_valid || out_drop) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got valid=%0b drop=%0b data=%02h, need no output",
                             out_valid, out_drop, out_data);
                end else begin
                    e = sb.pop_front();
                    if (e.drop) begin
                        if (!out_drop || out_valid) begin
                            n_fail++;
                            $display("FAIL drop: got valid=%0b drop=%0b, need valid=0 drop=1",
                                     out_valid, out_drop);
                        end
                    end else if (out_drop || !out_valid || out_data != e.data || out_last != e.last
                                 || (e.last && out_err != e.err)) begin
                        n_fail++;
                        $display("FAIL beat: got valid=%0b drop=%0b data=%02h last=%0b err=%03b, need data=%02h last=%0b err=%03b",
                                 out_valid, out_drop, out_data, out_last, out_err, e.data, e.last, e.err);
                    end
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        in_eop   = 1'b0;
        repeat (3) tick();
        check_quiet("reset_state");
        reset = 1'b0;
        repeat (70) tick();

        run_frame(64, 1'b0, 3);
        run_frame(64, 1'b1, 3);
        run_frame(20, 1'b0, 3);
        run_frame(3, 1'b0, 0);
`ifdef ETH_RX_STATS_EN
        n_tests++;
        if (stat_ok != 16'(exp_ok) || stat_bad != 16'(exp_bad)) begin
            n_fail++;
            $display("FAIL stats: got ok=%0d bad=%0d, need ok=%0d bad=%0d",
                     stat_ok, stat_bad, exp_ok, exp_bad);
        end
`endif

        // eop while idle must produce nothing
        in_eop = 1'b1;
        tick();
        in_eop = 1'b0;
        repeat (4) tick();

        run_frame(5, 1'b0, 1);
        run_frame(1522, 1'b0, 3);
        run_frame(2100, 1'b0, 0);

        for (int k = 0; k < 20; k++) begin
            run_frame(int'($urandom_range(1, 120)), ($urandom_range(0, 2) == 0),
                      int'($urandom_range(0, 3)));
        end

        build(64, 1'b0);
        expect_frame(30);
        send(3, 30, 32);
        run_frame(64, 1'b0, 3);

        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (64) tick();
        run_frame(64, 1'b0, 3);

        repeat (10) tick();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d expectations left, need 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
